mandel_job_dispatch: RTL and testbench

// Fans one stream of pixel jobs out to NUM_ENGINES Mandelbrot iteration engines; the

---
 rtl/mandel_job_dispatch.sv | 111 +++++++++++
 tb/tb_mandel_job_dispatch.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mandel_job_dispatch.sv
// One-entry job buffer that issues each accepted job to the next free engine in
// round-robin order, tagging the chosen engine on o_select for the gather side.
module mandel_job_dispatch #(
  parameter int DATA_WIDTH   = 12,
  parameter int NUM_ENGINES  = 15,
  parameter int SELECT_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [DATA_WIDTH-1:0]   i_data,
  input  logic [NUM_ENGINES-1:0]  i_busy,
  output logic [NUM_ENGINES-1:0]  o_start,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic [SELECT_WIDTH-1:0] o_select,
  output logic                    o_idle
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t                  state_reg, state_next;
  logic [DATA_WIDTH-1:0]   buf_reg, buf_next;
  logic [DATA_WIDTH-1:0]   data_reg, data_next;
  logic [NUM_ENGINES-1:0]  start_reg, start_next;
  logic [SELECT_WIDTH-1:0] sel_reg, sel_next;
  logic [SELECT_WIDTH-1:0] ptr_reg, ptr_next;

  logic [NUM_ENGINES-1:0]  free;
  logic                    found;
  logic [SELECT_WIDTH-1:0] pick;

  // An engine just pulsed has not raised i_busy yet, so its start bit masks it too.
  generate
    for (genvar gi = 0; gi < NUM_ENGINES; gi++) begin : g_free
      assign free[gi] = !i_busy[gi] && !start_reg[gi];
    end
  endgenerate

  // Round-robin: engines above ptr first, then wrap to 0..ptr.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NUM_ENGINES; k++) begin
      if (!found && free[k] && (k > int'(ptr_reg))) begin
        found = 1'b1;
        pick  = SELECT_WIDTH'(k);
      end
    end
    for (int k = 0; k < NUM_ENGINES; k++) begin
      if (!found && free[k] && (k <= int'(ptr_reg))) begin
        found = 1'b1;
        pick  = SELECT_WIDTH'(k);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= EMPTY;
      buf_reg   <= '0;
      data_reg  <= '0;
      start_reg <= '0;
      sel_reg   <= '0;
      ptr_reg   <= SELECT_WIDTH'(NUM_ENGINES - 1);
    end else begin
      state_reg <= state_next;
      buf_reg   <= buf_next;
      data_reg  <= data_next;
      start_reg <= start_next;
      sel_reg   <= sel_next;
      ptr_reg   <= ptr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    buf_next   = buf_reg;
    data_next  = data_reg;
    start_next = '0;
    sel_next   = sel_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      EMPTY: begin
        if (i_valid) begin
          buf_next   = i_data;
          state_next = FULL;
        end
      end
      FULL: begin
        if (found) begin
          start_next = NUM_ENGINES'(1) << pick;
          data_next  = buf_reg;
          sel_next   = pick;
          ptr_next   = pick;
          state_next = EMPTY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_comb begin
    o_ready  = (state_reg == EMPTY);
    o_start  = start_reg;
    o_data   = data_reg;
    o_select = sel_reg;
    o_idle   = (state_reg == EMPTY) && (i_busy == '0) && (start_reg == '0);
  end

endmodule

// File: tb/tb_mandel_job_dispatch.sv
// Bench for mandel_job_dispatch: per-cycle comparison against a queue-free behavioural
// model, directed scenarios with literal expectations, then a long random run.
module tb_mandel_job_dispatch;

  localparam int N  = 15;
  localparam int DW = 12;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          i_valid = 1'b0;
  logic          o_ready;
  logic [DW-1:0] i_data = '0;
  logic [N-1:0]  i_busy;
  logic [N-1:0]  o_start;
  logic [DW-1:0] o_data;
  logic [SW-1:0] o_select;
  logic          o_idle;

  int n_tests = 0;
  int n_fail  = 0;

  logic [N-1:0] busy_man = '0;
  logic [N-1:0] eng_busy;
  logic         auto_en = 1'b0;
  logic         rand_len = 1'b0;
  int           cnt [N];

  int low_cnt = 0;
  int sel_log [$];
  logic [N-1:0] last_busy = '0;

  // Model state: whole-job view with integer engine numbers.
  logic          m_full;
  logic [DW-1:0] m_buf, m_data;
  int            m_ptr, m_start, m_sel;

  always #5 clk = ~clk;

  assign i_busy = (auto_en ? eng_busy : '0) | busy_man;

  mandel_job_dispatch #(.DATA_WIDTH(DW), .NUM_ENGINES(N), .SELECT_WIDTH(SW)) dut (
    .clk(clk), .reset_n(reset_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_busy(i_busy), .o_start(o_start), .o_data(o_data),
    .o_select(o_select), .o_idle(o_idle)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Engines: busy from the cycle after their start pulse for a fixed or random length.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < N; k++) cnt[k] <= 0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (o_start[k]) cnt[k] <= rand_len ? int'($urandom_range(1, 8)) : 3;
        else if (cnt[k] != 0) cnt[k] <= cnt[k] - 1;
      end
    end
  end

  always_comb begin
    eng_busy = '0;
    for (int k = 0; k < N; k++) eng_busy[k] = (cnt[k] != 0);
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_full  <= 1'b0;
      m_buf   <= '0;
      m_data  <= '0;
      m_ptr   <= N - 1;
      m_start <= -1;
      m_sel   <= 0;
    end else begin
      int hit;
      hit = -1;
      m_start <= -1;
      if (m_full) begin
        for (int off = 1; off <= N && hit < 0; off++) begin
          int e;
          e = (m_ptr + off) % N;
          if (!i_busy[e] && m_start != e) hit = e;
        end
        if (hit >= 0) begin
          m_start <= hit;
          m_data  <= m_buf;
          m_sel   <= hit;
          m_ptr   <= hit;
          m_full  <= 1'b0;
        end
      end else if (i_valid) begin
        m_full <= 1'b1;
        m_buf  <= i_data;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      logic [N-1:0] exp_start;
      exp_start = (m_start < 0) ? '0 : (N'(1) << m_start);
      chk("ready", int'(o_ready), int'(!m_full));
      chk("start", int'(o_start), int'(exp_start));
      chk("data", int'(o_data), int'(m_data));
      chk("select", int'(o_select), m_sel);
      chk("idle", int'(o_idle), int'(!m_full && i_busy == '0 && m_start < 0));
      chk("onehot", int'($countones(o_start) <= 1), 1);
      chk("start_to_busy", int'(o_start & last_busy), 0);
      if (!o_ready) low_cnt++;
      if (o_start != '0) sel_log.push_back(int'(o_select));
    end
    last_busy = i_busy;
  end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d);
    logic acc;
    acc = 1'b0;
    align();
    i_valid = 1'b1;
    i_data  = d;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (o_ready) begin
        acc = 1'b1;
        break;
      end
    end
    align();
    i_valid = 1'b0;
    chk("send_accept", int'(acc), 1);
  endtask

  task automatic wait_start(output int sel);
    logic got;
    got = 1'b0;
    sel = -1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (o_start != '0) begin
        got = 1'b1;
        sel = int'(o_select);
        break;
      end
    end
    chk("start_seen", int'(got), 1);
  endtask

  task automatic do_reset();
    align();
    reset_n = 1'b0;
    align();
    align();
    reset_n = 1'b1;
  endtask

  initial begin
    int s;
    do_reset();

    // 1: single job, two-cycle latency
    chk("rst_ready", int'(o_ready), 1);
    chk("rst_start", int'(o_start), 0);
    chk("rst_idle", int'(o_idle), 1);
    send(12'h0A5);
    @(negedge clk);
    chk("t1_no_start_yet", int'(o_start), 0);
    @(negedge clk);
    chk("t1_start", int'(o_start), 16'h0001);
    chk("t1_data", int'(o_data), 12'h0A5);
    chk("t1_select", int'(o_select), 0);

    // 2: sixteen jobs through free engines
    do_reset();
    auto_en = 1'b1;
    low_cnt = 0;
    sel_log.delete();
    for (int j = 0; j < 16; j++) send(DW'(12'h100 + j));
    repeat (6) @(negedge clk);
    chk("t2_ready_low_cycles", low_cnt, 16);
    chk("t2_issue_count", sel_log.size(), 16);
    for (int j = 0; j < sel_log.size() && j < 16; j++)
      chk($sformatf("t2_select_%0d", j), sel_log[j], j % 15);
    auto_en = 1'b0;

    // 3: all busy, then release engine 6
    align();
    busy_man = 15'h7FFF;
    send(12'h3C3);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t3_held_ready", int'(o_ready), 0);
      chk("t3_held_start", int'(o_start), 0);
    end
    align();
    busy_man = 15'h7FBF;
    @(negedge clk);
    chk("t3_same_cycle", int'(o_start), 0);
    @(negedge clk);
    chk("t3_start", int'(o_start), 16'h0040);
    chk("t3_data", int'(o_data), 12'h3C3);

    // 4: wrap from engine 14 to engine 0, then engine 3
    align();
    busy_man = 15'h3FFF;
    send(12'h401);
    wait_start(s);
    chk("t4_to_14", s, 14);
    align();
    busy_man = 15'h7FF6;
    send(12'h402);
    wait_start(s);
    chk("t4_wrap_0", s, 0);
    send(12'h403);
    wait_start(s);
    chk("t4_then_3", s, 3);
    chk("t4_data", int'(o_data), 12'h403);

    // 5: reset while FULL and while o_start is high
    align();
    busy_man = 15'h7FFF;
    send(12'h501);
    align();
    reset_n = 1'b0;
    #1;
    chk("t5a_ready", int'(o_ready), 1);
    chk("t5a_start", int'(o_start), 0);
    chk("t5a_data", int'(o_data), 0);
    chk("t5a_select", int'(o_select), 0);
    align();
    reset_n = 1'b1;
    busy_man = '0;
    send(12'h502);
    wait_start(s);
    chk("t5a_next_eng", s, 0);
    send(12'h503);
    wait_start(s);
    chk("t5b_eng1", s, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5b_start", int'(o_start), 0);
    chk("t5b_data", int'(o_data), 0);
    chk("t5b_select", int'(o_select), 0);
    chk("t5b_ready", int'(o_ready), 1);
    align();
    reset_n = 1'b1;
    send(12'h504);
    wait_start(s);
    chk("t5b_next_eng", s, 0);

    // 6: random traffic checked against the model every cycle
    auto_en  = 1'b1;
    rand_len = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      logic hold;
      @(negedge clk);
      hold = i_valid && !o_ready;
      @(posedge clk);
      #1;
      if (!hold) begin
        i_valid = 1'($urandom_range(0, 1));
        i_data  = DW'($urandom);
      end
      if (c % 64 == 0) busy_man = N'($urandom & $urandom & $urandom);
    end
    align();
    i_valid  = 1'b0;
    busy_man = '0;
    repeat (40) @(negedge clk);
    chk("t6_idle_at_end", int'(o_idle), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
